rns_seq_converter: RTL

RNS_SEQ_CONVERTER -- requirements
Module: rns_seq_converter

---
 rtl/rns_pkg.sv | 15 +
 rtl/rns_mod_counter.sv | 31 +++
 rtl/rns_seq_converter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rns_pkg.sv
// Shared definitions for the residue-number-system sequential converter.
// Holds the default residue/result widths and the converter state encoding.
package rns_pkg;

  localparam int RW_DEF = 8;   // width of each modulus and residue
  localparam int XW_DEF = 15;  // width of the binary result

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    SEARCH = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/rns_mod_counter.sv
// Wrapping modulo counter used to track one residue channel during the search.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : synchronous clear to zero (has priority over en)
//   en         : advance one step
//   modulus    : counter wraps from modulus-1 back to 0
//   r          : current residue value
module rns_mod_counter
  import rns_pkg::*;
#(
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [RW-1:0] modulus,
  output logic [RW-1:0] r
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
    end else if (clr) begin
      r <= '0;
    end else if (en) begin
      r <= (r == modulus - RW'(1)) ? '0 : r + RW'(1);
    end
  end

endmodule

// File: rtl/rns_seq_converter.sv
// Sequential residue-to-binary converter for three moduli.
// After validating the operands, it counts cnt = 0,1,2,... while three modulo
// counters track (cnt mod m1, cnt mod m2, cnt mod m3); the first cnt whose
// residues equal (x1,x2,x3) is the result. Reaching M-1 without a match means
// the moduli are not pairwise coprime.
// Ports:
//   clk, rst_n     : clock and asynchronous active-low reset
//   start          : conversion request, honoured only in IDLE
//   m1, m2, m3     : moduli, captured with start
//   x1, x2, x3     : residues, captured with start
//   busy           : high whenever not in IDLE
//   done           : one-cycle pulse ending a conversion
//   err            : conversion failed; valid with done, held until next start
//   x              : binary result; valid with done, held until next start
module rns_seq_converter
  import rns_pkg::*;
#(
  parameter int RW = RW_DEF,
  parameter int XW = XW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [RW-1:0] m1,
  input  logic [RW-1:0] m2,
  input  logic [RW-1:0] m3,
  input  logic [RW-1:0] x1,
  input  logic [RW-1:0] x2,
  input  logic [RW-1:0] x3,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [XW-1:0] x
);

  localparam int PW = 3 * RW;

  state_t        state, state_nx;
  logic [RW-1:0] m1_q, m2_q, m3_q;
  logic [RW-1:0] x1_q, x2_q, x3_q;
  logic [RW-1:0] r1, r2, r3;
  logic [PW-1:0] prod;
  logic [XW-1:0] m_q;
  logic [XW-1:0] cnt;
  logic          chk_fail;
  logic          match;
  logic          last;
  logic          accept;
  logic          ctr_clr;
  logic          ctr_en;

  // Full-width product so an oversized M is detected rather than truncated.
  assign prod = PW'(m1_q) * PW'(m2_q) * PW'(m3_q);

  assign chk_fail = (m1_q < RW'(2)) || (m2_q < RW'(2)) || (m3_q < RW'(2)) ||
                    (x1_q >= m1_q) || (x2_q >= m2_q) || (x3_q >= m3_q) ||
                    ((prod >> XW) != '0);

  assign match = (r1 == x1_q) && (r2 == x2_q) && (r3 == x3_q);
  assign last  = (cnt == m_q - XW'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    ctr_clr  = 1'b0;
    ctr_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = CHECK;
        end
      end
      CHECK: begin
        ctr_clr  = 1'b1;
        state_nx = chk_fail ? DONE : SEARCH;
      end
      SEARCH: begin
        if (match || last) begin
          state_nx = DONE;
        end else begin
          ctr_en = 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Operand capture; pure data, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      m1_q <= m1;
      m2_q <= m2;
      m3_q <= m3;
      x1_q <= x1;
      x2_q <= x2;
      x3_q <= x3;
    end
  end

  // M is latched once in CHECK; only its low XW bits matter once CHECK passes.
  always_ff @(posedge clk) begin
    if (state == CHECK) begin
      m_q <= prod[XW-1:0];
    end
  end

  // Search counter; cannot wrap because M <= 2^XW - 1 is enforced in CHECK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ctr_clr) begin
      cnt <= '0;
    end else if (ctr_en) begin
      cnt <= cnt + XW'(1);
    end
  end

  // Result and error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
      x   <= '0;
    end else if (accept) begin
      err <= 1'b0;
      x   <= '0;
    end else if (state == CHECK && chk_fail) begin
      err <= 1'b1;
      x   <= '0;
    end else if (state == SEARCH) begin
      if (match) begin
        x <= cnt;
      end else if (last) begin
        err <= 1'b1;
        x   <= '0;
      end
    end
  end

  rns_mod_counter #(.RW(RW)) u_ctr1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .modulus (m1_q),
    .r       (r1)
  );

  rns_mod_counter #(.RW(RW)) u_ctr2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .modulus (m2_q),
    .r       (r2)
  );

  rns_mod_counter #(.RW(RW)) u_ctr3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .modulus (m3_q),
    .r       (r3)
  );

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
